// File: rtl/nibble_sub_sequencer_if.sv
// rtl/nibble_sub_sequencer_if.sv - requester and slice signal bundle for nibble_sub_sequencer
interface nibble_sub_sequencer_if #(
    parameter int WIDTH = 16
);
    // requester side
    logic             start;
    logic [0:WIDTH-1] a;
    logic [0:WIDTH-1] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [0:WIDTH-1] diff;
    logic             borrow_out;
    logic             zero;
    // shared 4-bit subtractor slice side
    logic [0:3]       sub_in1;
    logic [0:3]       sub_in2;
    logic             sub_bin;
    logic [0:3]       sub_out;
    logic             sub_bout;

    modport slave (
        input  start, a, b, borrow_in, sub_out, sub_bout,
        output busy, done, diff, borrow_out, zero, sub_in1, sub_in2, sub_bin
    );

    modport master (
        output start, a, b, borrow_in, sub_out, sub_bout,
        input  busy, done, diff, borrow_out, zero, sub_in1, sub_in2, sub_bin
    );
endinterface

// File: rtl/nibble_sub_sequencer.sv
// rtl/nibble_sub_sequencer.sv - WIDTH-bit subtract sequenced over a registered 4-bit slice
module nibble_sub_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_sub_sequencer_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [0:WIDTH-1] a_q, a_d;
    logic [0:WIDTH-1] b_q, b_d;
    logic             br_q, br_d;
    // work holds partial nibbles; diff only changes when the whole result is ready
    logic [0:WIDTH-1] work_q, work_d;
    logic [0:WIDTH-1] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    logic [0:3]       sub_in1_c;
    logic [0:3]       sub_in2_c;
    logic             sub_bin_c;

    // state and datapath registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            work_q  <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            work_q  <= work_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    // next-state and nibble sequencing; results commit on the edge entering DONE
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        work_d  = work_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.borrow_in;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                for (int n = 0; n < NIB; n++) begin
                    if (k_q == KW'(n)) begin
                        work_d[WIDTH-4-4*n +: 4] = bus.sub_out;
                    end
                end
                br_d = bus.sub_bout;
                if (k_q == K_LAST) begin
                    diff_d  = work_d;
                    bout_d  = bus.sub_bout;
                    zero_d  = (work_d == '0);
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // slice inputs are driven only in ISSUE, from latched operands and chained borrow
    always_comb begin
        sub_in1_c = '0;
        sub_in2_c = '0;
        sub_bin_c = 1'b0;
        if (state_q == S_ISSUE) begin
            sub_bin_c = br_q;
            for (int n = 0; n < NIB; n++) begin
                if (k_q == KW'(n)) begin
                    sub_in1_c = a_q[WIDTH-4-4*n +: 4];
                    sub_in2_c = b_q[WIDTH-4-4*n +: 4];
                end
            end
        end
    end

    assign bus.sub_in1    = sub_in1_c;
    assign bus.sub_in2    = sub_in2_c;
    assign bus.sub_bin    = sub_bin_c;
    assign bus.busy       = (state_q == S_ISSUE) || (state_q == S_CAPTURE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bout_q;
    assign bus.zero       = zero_q;
endmodule
